// File: rtl/debug_pkg.sv
// Shared debug types: controller function codes, responder states and the
// byte-lane formatting helpers used on the data memory path.
package debug_pkg;

   typedef enum logic [3:0] {
      FN_NONE,
      FN_PAUSE,
      FN_RESUME,
      FN_RESET,
      FN_REG_RD,
      FN_REG_WR,
      FN_MEM_RD,
      FN_MEM_WR,
      FN_MULTI
   } debug_fn_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PAUSE,
      S_RESUME,
      S_RST,
      S_REG_RD,
      S_REG_WR,
      S_MEM,
      S_ERR
   } state_e;

   // cmd bit order: pause, resume, db_reset, reg_rd, reg_wr, mem_rd, mem_wr
   function automatic debug_fn_e decode_fn(input logic [6:0] cmd);
      case (cmd)
         7'b0000000: decode_fn = FN_NONE;
         7'b1000000: decode_fn = FN_PAUSE;
         7'b0100000: decode_fn = FN_RESUME;
         7'b0010000: decode_fn = FN_RESET;
         7'b0001000: decode_fn = FN_REG_RD;
         7'b0000100: decode_fn = FN_REG_WR;
         7'b0000010: decode_fn = FN_MEM_RD;
         7'b0000001: decode_fn = FN_MEM_WR;
         default:    decode_fn = FN_MULTI;
      endcase
   endfunction

   function automatic logic [31:0] fmt_wdata(input logic byte_en, input logic [31:0] d);
      fmt_wdata = byte_en ? {4{d[7:0]}} : d;
   endfunction

   function automatic logic [31:0] fmt_rdata(input logic byte_en, input logic [31:0] d);
      fmt_rdata = byte_en ? {24'd0, d[7:0]} : d;
   endfunction

endpackage

// File: rtl/db_mem_port.sv
// Data memory request port: holds the request until dm_ack or timeout and
// reports completion to the responder FSM with a one-cycle done/err strobe.
module db_mem_port
   import debug_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        wr,
   input  logic        byte_en,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic        dm_re,
   output logic        dm_we,
   output logic        dm_byte,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata
);

   localparam int TMR_W = $clog2(MEM_TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

   logic [31:0]      dm_addr_q, dm_addr_d;
   logic [31:0]      dm_wdata_q, dm_wdata_d;
   logic             dm_re_q, dm_re_d;
   logic             dm_we_q, dm_we_d;
   logic             dm_byte_q, dm_byte_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      dm_addr_d  = dm_addr_q;
      dm_wdata_d = dm_wdata_q;
      dm_re_d    = dm_re_q;
      dm_we_d    = dm_we_q;
      dm_byte_d  = dm_byte_q;
      tmr_d      = tmr_q;
      done       = 1'b0;
      err        = 1'b0;
      rdata      = '0;
      if (start) begin
         dm_addr_d  = addr;
         dm_wdata_d = fmt_wdata(byte_en, wdata);
         dm_byte_d  = byte_en;
         dm_re_d    = !wr;
         dm_we_d    = wr;
         tmr_d      = '0;
      end else if (dm_re_q || dm_we_q) begin
         // An ack on the final timeout cycle wins over the timeout.
         if (dm_ack) begin
            done    = 1'b1;
            rdata   = fmt_rdata(dm_byte_q, dm_rdata);
            dm_re_d = 1'b0;
            dm_we_d = 1'b0;
         end else if (tmr_q == TMR_LAST) begin
            done    = 1'b1;
            err     = 1'b1;
            dm_re_d = 1'b0;
            dm_we_d = 1'b0;
         end else begin
            tmr_d = tmr_q + 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         dm_addr_q  <= '0;
         dm_wdata_q <= '0;
         dm_re_q    <= 1'b0;
         dm_we_q    <= 1'b0;
         dm_byte_q  <= 1'b0;
         tmr_q      <= '0;
      end else begin
         dm_addr_q  <= dm_addr_d;
         dm_wdata_q <= dm_wdata_d;
         dm_re_q    <= dm_re_d;
         dm_we_q    <= dm_we_d;
         dm_byte_q  <= dm_byte_d;
         tmr_q      <= tmr_d;
      end
   end

   assign dm_addr  = dm_addr_q;
   assign dm_wdata = dm_wdata_q;
   assign dm_re    = dm_re_q;
   assign dm_we    = dm_we_q;
   assign dm_byte  = dm_byte_q;

endmodule

// File: rtl/mcu_db_responder.sv
// MCU-side debug responder: executes controller commands against the core's
// stall/reset controls, register file and data memory.
module mcu_db_responder
   import debug_pkg::*;
#(
   parameter bit START_PAUSED = 1'b0,
   parameter int RST_CYCLES   = 4,
   parameter int MEM_TIMEOUT  = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] d_in,
   input  logic [31:0] addr,
   input  logic        pause,
   input  logic        resume,
   input  logic        db_reset,
   input  logic        reg_rd,
   input  logic        reg_wr,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic        mem_rw_byte,
   input  logic        valid,
   output logic        mcu_busy,
   output logic [31:0] d_rd,
   output logic        error,
   output logic        core_stall,
   output logic        core_reset,
   input  logic        instr_bound,
   output logic [4:0]  rf_addr,
   output logic [31:0] rf_wdata,
   output logic        rf_we,
   input  logic [31:0] rf_rdata,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic        dm_re,
   output logic        dm_we,
   output logic        dm_byte,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata
);

   localparam int CNT_W = (RST_CYCLES > 2) ? $clog2(RST_CYCLES) : 1;
   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);

   state_e           state_q, state_d;
   logic             paused_q, paused_d;
   logic             core_stall_q, core_stall_d;
   logic             core_reset_q, core_reset_d;
   logic [4:0]       rf_addr_q, rf_addr_d;
   logic [31:0]      rf_wdata_q, rf_wdata_d;
   logic             rf_we_q, rf_we_d;
   logic [31:0]      d_rd_q, d_rd_d;
   logic             error_q, error_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   debug_fn_e        fn;
   logic             mem_start, mem_done, mem_err;
   logic [31:0]      mem_rdata;

   always_comb begin
      state_d      = state_q;
      paused_d     = paused_q;
      core_stall_d = core_stall_q;
      core_reset_d = core_reset_q;
      rf_addr_d    = rf_addr_q;
      rf_wdata_d   = rf_wdata_q;
      rf_we_d      = 1'b0;
      d_rd_d       = d_rd_q;
      error_d      = error_q;
      cnt_d        = cnt_q;
      mem_start    = 1'b0;
      fn           = decode_fn({pause, resume, db_reset, reg_rd, reg_wr, mem_rd, mem_wr});
      case (state_q)
         S_IDLE: if (valid && fn != FN_NONE) begin
            error_d = 1'b0;
            case (fn)
               FN_PAUSE: begin
                  state_d      = S_PAUSE;
                  core_stall_d = 1'b1;
               end
               FN_RESUME: begin
                  state_d      = S_RESUME;
                  core_stall_d = 1'b0;
                  paused_d     = 1'b0;
               end
               FN_RESET: begin
                  state_d      = S_RST;
                  core_reset_d = 1'b1;
                  cnt_d        = RST_LAST;
               end
               FN_REG_RD, FN_REG_WR: begin
                  if (!paused_q || addr[31:5] != '0) begin
                     state_d = S_ERR;
                  end else begin
                     rf_addr_d = addr[4:0];
                     cnt_d     = '0;
                     if (fn == FN_REG_WR) begin
                        state_d    = S_REG_WR;
                        rf_wdata_d = d_in;
                        rf_we_d    = (addr[4:0] != 5'd0);
                     end else begin
                        state_d = S_REG_RD;
                     end
                  end
               end
               FN_MEM_RD, FN_MEM_WR: begin
                  if (!paused_q || (!mem_rw_byte && addr[1:0] != 2'd0)) begin
                     state_d = S_ERR;
                  end else begin
                     state_d   = S_MEM;
                     mem_start = 1'b1;
                  end
               end
               default: state_d = S_ERR;
            endcase
         end
         S_PAUSE: if (paused_q || instr_bound) begin
            paused_d = 1'b1;
            state_d  = S_IDLE;
         end
         S_RESUME: state_d = S_IDLE;
         S_RST: begin
            if (cnt_q == '0) begin
               core_reset_d = 1'b0;
               state_d      = S_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         // First cycle presents rf_addr; second captures the registered read data.
         S_REG_RD: begin
            if (cnt_q == '0) begin
               cnt_d = CNT_W'(1);
            end else begin
               d_rd_d  = rf_rdata;
               state_d = S_IDLE;
            end
         end
         S_REG_WR: state_d = S_IDLE;
         S_MEM: if (mem_done) begin
            if (mem_err || dm_re) d_rd_d = mem_rdata;
            error_d = mem_err;
            state_d = S_IDLE;
         end
         S_ERR: begin
            error_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         paused_q     <= START_PAUSED;
         core_stall_q <= START_PAUSED;
         core_reset_q <= 1'b0;
         rf_addr_q    <= '0;
         rf_wdata_q   <= '0;
         rf_we_q      <= 1'b0;
         d_rd_q       <= '0;
         error_q      <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         paused_q     <= paused_d;
         core_stall_q <= core_stall_d;
         core_reset_q <= core_reset_d;
         rf_addr_q    <= rf_addr_d;
         rf_wdata_q   <= rf_wdata_d;
         rf_we_q      <= rf_we_d;
         d_rd_q       <= d_rd_d;
         error_q      <= error_d;
         cnt_q        <= cnt_d;
      end
   end

   db_mem_port #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_port (
      .clk      (clk),
      .reset    (reset),
      .start    (mem_start),
      .wr       (fn == FN_MEM_WR),
      .byte_en  (mem_rw_byte),
      .addr     (addr),
      .wdata    (d_in),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_re    (dm_re),
      .dm_we    (dm_we),
      .dm_byte  (dm_byte),
      .dm_ack   (dm_ack),
      .dm_rdata (dm_rdata),
      .done     (mem_done),
      .err      (mem_err),
      .rdata    (mem_rdata)
   );

   assign mcu_busy   = (state_q != S_IDLE);
   assign d_rd       = d_rd_q;
   assign error      = error_q;
   assign core_stall = core_stall_q;
   assign core_reset = core_reset_q;
   assign rf_addr    = rf_addr_q;
   assign rf_wdata   = rf_wdata_q;
   assign rf_we      = rf_we_q;

endmodule
